// File: rtl/irda_tx_controller.sv
// IrDA SIR transmit sequencer: frames one byte per handshake (start, LSB-first data, stop)
// and drives a 3/16-period return-to-zero pulse for every 0 bit, paced by baud_tick.
module irda_tx_controller #(
    parameter int DATA_BITS    = 8,
    parameter int PULSE_CYCLES = 244,
    parameter int PCNT_W       = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    output logic                 baud_run,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 irda_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int FRAME_W = DATA_BITS + 2;
    localparam int BCNT_W  = $clog2(DATA_BITS + 2);
    localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(DATA_BITS + 1);
    localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEND
    } state_t;

    state_t              state, state_next;
    logic [FRAME_W-1:0]  shreg, shreg_next;
    logic [BCNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [PCNT_W-1:0]   pcnt, pcnt_next;
    logic                done_next;

    assign tx_ready = (state == IDLE) && !reset;

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        pcnt_next    = (pcnt != '0) ? pcnt - PCNT_W'(1) : '0;
        done_next    = 1'b0;

        unique case (state)
            IDLE: begin
                // A tick coinciding with the handshake is deliberately not used here.
                if (tx_valid && tx_ready) begin
                    shreg_next   = {1'b1, tx_data, 1'b0};
                    bit_cnt_next = '0;
                    state_next   = ARM;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    state_next = SEND;
                    pcnt_next  = shreg[0] ? '0 : PULSE_LOAD;
                end
            end
            SEND: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BCNT_W'(1);
                        shreg_next   = shreg >> 1;
                        // A tick over a still-running pulse restarts or clears it, never merges.
                        pcnt_next    = shreg[1] ? '0 : PULSE_LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            pcnt     <= '0;
            irda_out <= 1'b0;
            baud_run <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            pcnt     <= pcnt_next;
            irda_out <= (pcnt_next != '0);
            baud_run <= (state_next != IDLE);
            busy     <= (state_next != IDLE);
            tx_done  <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_next;
    end

endmodule

// File: tb/tb_irda_tx_controller.sv
// Bench for irda_tx_controller: environment baud counter, timestamp-based frame model
// checked every cycle, plus directed frames with hand-computed pulse patterns.
module tb_irda_tx_controller;

    localparam int DATA_BITS = 8;
    localparam int BIT_P     = 326;
    localparam int PULSE     = 61;
    localparam int PCNT_W    = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       stray = 1'b0;
    logic       baud_tick, baud_run, tx_ready, irda_out, busy, tx_done;

    int cnt = 0;

    irda_tx_controller #(
        .DATA_BITS(DATA_BITS),
        .PULSE_CYCLES(PULSE),
        .PCNT_W(PCNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .baud_tick(baud_tick),
        .baud_run(baud_run),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .irda_out(irda_out),
        .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Baud counter held at zero while baud_run is low
    always @(posedge clk) begin
        if (baud_run !== 1'b1)     cnt <= 0;
        else if (cnt == BIT_P - 1) cnt <= 0;
        else                       cnt <= cnt + 1;
    end
    assign baud_tick = stray | ((baud_run === 1'b1) && (cnt == BIT_P - 1));

    int n_chk = 0;
    int n_fail = 0;
    int ncyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Model: phase 0 idle, 1 armed, 2 sending; pulses derived from tick timestamps
    int         m_ph = 0, m_k = 0, m_last = 0, mcyc = 0;
    logic [9:0] m_bits = '0;
    bit         m_done = 0;
    bit         live = 0;
    logic       s_tick = 0, s_valid = 0, s_reset = 1;
    logic [7:0] s_data = 0;

    always @(posedge clk) begin
        mcyc++;
        if (s_reset) begin
            m_ph   = 0;
            m_done = 0;
            live   = 1;
        end else begin
            m_done = 0;
            case (m_ph)
                0: if (s_valid) begin
                    m_bits = {1'b1, s_data, 1'b0};
                    m_k    = 0;
                    m_ph   = 1;
                end
                1: if (s_tick) begin
                    m_ph   = 2;
                    m_k    = 0;
                    m_last = mcyc;
                end
                default: if (s_tick) begin
                    if (m_k == DATA_BITS + 1) begin
                        m_ph   = 0;
                        m_done = 1;
                    end else begin
                        m_k++;
                        m_last = mcyc;
                    end
                end
            endcase
        end
    end

    int   frm_ticks = 0, pulse_mask = 0, pulse_cnt = 0, first_rise = -1, cur_w = 0;
    int   done_cnt = 0, accept_cnt = 0, accept_cyc = 0, done_cyc = 0;
    int   last_mask = 0, last_cnt = 0, last_ticks = 0;
    logic prev_irda = 0;

    always @(negedge clk) begin
        logic exp_irda;
        ncyc++;
        if (live) begin
            exp_irda = (m_ph == 2) && (m_bits[m_k] == 1'b0) && ((mcyc - m_last) < PULSE);
            chk("irda_out", 32'(irda_out), 32'(exp_irda));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            chk("baud_run", 32'(baud_run), 32'(m_ph != 0));
            chk("tx_done", 32'(tx_done), 32'(m_done));
            chk("tx_ready", 32'(tx_ready), 32'((m_ph == 0) && !reset));

            if (baud_tick && baud_run) frm_ticks++;
            if (irda_out && !prev_irda) begin
                pulse_cnt++;
                pulse_mask |= (1 << (frm_ticks - 1));
                if (first_rise < 0) first_rise = ncyc;
                cur_w = 0;
            end
            if (irda_out) cur_w++;
            if (!irda_out && prev_irda && !s_reset) chk("pulse_width", cur_w, PULSE);
            prev_irda = irda_out;
            if (tx_done) begin
                done_cnt++;
                done_cyc   = ncyc;
                last_mask  = pulse_mask;
                last_cnt   = pulse_cnt;
                last_ticks = frm_ticks;
            end
            if (tx_valid && tx_ready) begin
                accept_cnt++;
                accept_cyc = ncyc;
                frm_ticks  = 0;
                pulse_mask = 0;
                pulse_cnt  = 0;
                first_rise = -1;
            end
        end
        s_tick  = baud_tick;
        s_valid = tx_valid;
        s_data  = tx_data;
        s_reset = reset;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        int t = 0;
        int start = accept_cnt;
        tx_data  = d;
        tx_valid = 1'b1;
        while (accept_cnt == start && t < 5000) begin
            step(1);
            t++;
        end
        if (accept_cnt == start) chk("accept_timeout", 0, 1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        int start = done_cnt;
        while (done_cnt == start && t < 6000) begin
            step(1);
            t++;
        end
        if (done_cnt == start) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic frame_checks(input string nm, input int mask, input int npulse);
        chk({nm, "_mask"}, last_mask, mask);
        chk({nm, "_pulses"}, last_cnt, npulse);
        chk({nm, "_ticks"}, last_ticks, 11);
    endtask

    initial begin
        int d0, acc0, ff_done, t;

        step(3);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            stray = (i % 7 == 0);
            step(1);
        end
        stray = 1'b0;
        chk("idle_tx_ready", 32'(tx_ready), 1);
        chk("idle_baud_run", 32'(baud_run), 0);
        chk("idle_irda", 32'(irda_out), 0);

        send(8'h55, 0);
        wait_done("x55");
        frame_checks("x55", 'h155, 5);
        chk("x55_first_pulse", first_rise - accept_cyc, BIT_P + 1);
        chk("x55_busy_after", 32'(busy), 0);

        send(8'hFF, 1);
        tx_data = 8'h00;
        wait_done("xFF");
        tx_valid = 1'b0;
        frame_checks("xFF", 'h1, 1);
        ff_done = done_cyc;
        chk("x00_accept_at_done", accept_cyc, ff_done);
        wait_done("x00");
        frame_checks("x00", 'h1FF, 9);
        chk("x00_gap", first_rise - ff_done, BIT_P + 1);

        send(8'hA3, 0);
        step(300);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        acc0 = accept_cnt;
        step(2000);
        tx_valid = 1'b0;
        chk("xA3_no_accept", accept_cnt, acc0);
        wait_done("xA3");
        frame_checks("xA3", 'hB9, 5);
        step(2);
        chk("xA3_idle_after", 32'(busy), 0);

        send(8'h00, 0);
        t = 0;
        while (!(frm_ticks == 3 && irda_out) && t < 5000) begin
            step(1);
            t++;
        end
        chk("rst_reached_p2", 32'(irda_out), 1);
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_irda", 32'(irda_out), 0);
        chk("rst_baud_run", 32'(baud_run), 0);
        chk("rst_busy", 32'(busy), 0);
        d0 = done_cnt;
        step(400);
        chk("rst_no_done", done_cnt, d0);

        send(8'hFE, 0);
        wait_done("xFE");
        frame_checks("xFE", 'h3, 2);

        step(5);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        stray    = 1'b1;
        step(1);
        tx_valid = 1'b0;
        stray    = 1'b0;
        chk("coll_busy", 32'(busy), 1);
        chk("coll_baud_run", 32'(baud_run), 1);
        chk("coll_irda", 32'(irda_out), 0);
        wait_done("x0F");
        frame_checks("x0F", 'h1E1, 5);
        chk("coll_first_pulse", first_rise - accept_cyc, BIT_P + 1);

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
